// File: rtl/ram_decoded_reader_if.sv
// Signal bundle between the block reader, the block store and the byte sink.
// master = the reader, slave = the store/sink side.
interface ram_decoded_reader_if;
  logic        start;
  logic [7:0]  avl_blocks_nb;
  logic [40:0] block_wanted;
  logic        data_ready;
  logic [7:0]  block_wanted_number;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, avl_blocks_nb, block_wanted, data_ready, tx_ready,
    output block_wanted_number, tx_data, tx_valid, busy, done, error
  );

  modport slave (
    output start, avl_blocks_nb, block_wanted, data_ready, tx_ready,
    input  block_wanted_number, tx_data, tx_valid, busy, done, error
  );
endinterface

// File: rtl/ram_decoded_reader.sv
// Fetches N stored blocks over a request/ready handshake and streams them as a byte frame.
// Optional trailing XOR checksum byte is enabled by defining READER_CHECKSUM_EN.
//
// state      | meaning
// IDLE       | waiting for start
// HEADER     | sending 0xA5
// COUNT      | sending block count N
// REQ        | presenting block index k
// WAIT_READY | holding k until data_ready, then capture
// RELEASE    | index back to 0, waiting for data_ready low
// SEND       | sending 6 bytes of the captured block
// CHECKSUM   | sending XOR checksum (READER_CHECKSUM_EN only)
// DONE       | one-cycle done pulse
module ram_decoded_reader #(
  parameter int MAX_BLOCKS    = 20,
  parameter int FETCH_TIMEOUT = 1024
) (
  input  logic                 clk_96MHz,
  input  logic                 rst_n,
  ram_decoded_reader_if.master bus
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_COUNT, S_REQ, S_WAIT_READY, S_RELEASE, S_SEND, S_DONE
`ifdef READER_CHECKSUM_EN
    , S_CHECKSUM
`endif
  } state_e;

`ifdef READER_CHECKSUM_EN
  localparam state_e S_TAIL = S_CHECKSUM;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e             state_q, state_d;
  logic [7:0]         n_q, n_d;
  logic [7:0]         k_q, k_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [40:0]        blk_q, blk_d;
`ifdef READER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic [7:0]  bwn;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        done_p;
  logic        error_p;
  logic [7:0]  send_byte;
  logic [47:0] word;
  logic        timeout;

  assign word    = {7'b0, blk_q};
  assign timeout = (cnt_q == CNT_W'(FETCH_TIMEOUT));

  always_comb begin
    send_byte = 8'h00;
    case (idx_q)
      3'd0:    send_byte = word[47:40];
      3'd1:    send_byte = word[39:32];
      3'd2:    send_byte = word[31:24];
      3'd3:    send_byte = word[23:16];
      3'd4:    send_byte = word[15:8];
      3'd5:    send_byte = word[7:0];
      default: send_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
`ifdef READER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    bwn     = 8'h00;
    tx_byte = 8'h00;
    tx_vld  = 1'b0;
    done_p  = 1'b0;
    error_p = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = (bus.avl_blocks_nb > 8'(MAX_BLOCKS)) ? 8'(MAX_BLOCKS) : bus.avl_blocks_nb;
          k_d     = 8'd1;
          idx_d   = 3'd0;
`ifdef READER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        tx_vld  = 1'b1;
        tx_byte = 8'hA5;
        if (bus.tx_ready) state_d = S_COUNT;
      end
      S_COUNT: begin
        tx_vld  = 1'b1;
        tx_byte = n_q;
        if (bus.tx_ready) begin
`ifdef READER_CHECKSUM_EN
          csum_d = csum_q ^ n_q;
`endif
          state_d = (n_q == 8'd0) ? S_TAIL : S_REQ;
        end
      end
      S_REQ: begin
        bwn     = k_q;
        state_d = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        // Timeout wins over a simultaneous data_ready so the bound is exact.
        if (timeout) begin
          error_p = 1'b1;
          state_d = S_IDLE;
        end else begin
          bwn = k_q;
          if (bus.data_ready) begin
            blk_d   = bus.block_wanted;
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (timeout) begin
          error_p = 1'b1;
          state_d = S_IDLE;
        end else if (!bus.data_ready) begin
          idx_d   = 3'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_vld  = 1'b1;
        tx_byte = send_byte;
        if (bus.tx_ready) begin
`ifdef READER_CHECKSUM_EN
          csum_d = csum_q ^ send_byte;
`endif
          if (idx_q == 3'd5) begin
            if (k_q == n_q) begin
              state_d = S_TAIL;
            end else begin
              k_d     = k_q + 8'd1;
              state_d = S_REQ;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef READER_CHECKSUM_EN
      S_CHECKSUM: begin
        tx_vld  = 1'b1;
        tx_byte = csum_q;
        if (bus.tx_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done_p  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_WAIT_READY || state_q == S_RELEASE)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = '0;
  end

  always_ff @(posedge clk_96MHz) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 8'h00;
      k_q     <= 8'h00;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      blk_q   <= '0;
`ifdef READER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
`ifdef READER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.block_wanted_number = bwn;
  assign bus.tx_data             = tx_byte;
  assign bus.tx_valid            = tx_vld;
  assign bus.busy                = (state_q != S_IDLE);
  assign bus.done                = done_p;
  assign bus.error               = error_p;

endmodule

// File: tb/tb_ram_decoded_reader.sv
// Directed bench for ram_decoded_reader: table of frame vectors plus timeout and reset sequences.
module tb_ram_decoded_reader;
  localparam int TIMEOUT = 1024;

  logic clk_96MHz = 1'b0;
  logic rst_n     = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  ram_decoded_reader_if bus();

  ram_decoded_reader #(.MAX_BLOCKS(20), .FETCH_TIMEOUT(TIMEOUT)) dut (
    .clk_96MHz(clk_96MHz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] avl;
    bit         stall;
    bit         restart;
    int         exp_n;
  } vec_t;

  int          n_err = 0;
  int          n_chk = 0;
  logic [40:0] blocks [0:31];
  logic [7:0]  rx [$];
  logic [7:0]  exp_q [$];
  int          req_log [$];
  int          done_cnt = 0, err_cnt = 0, cyc = 0;
  int          first_req_cyc = -1, err_cyc = -1;
  logic [7:0]  err_bwn = 8'h00;
  bit          store_en = 1'b1;
  bit          stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: transfers, pulses, request log and stall stability.
  initial begin : mon
    logic       pv, pr;
    logic [7:0] pd;
    logic [7:0] last;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; last = 8'h00;
    forever begin
      @(negedge clk_96MHz);
      cyc++;
      if (rst_n && pv && !pr) begin
        chk("stall_hold_valid", 64'(bus.tx_valid), 64'd1);
        chk("stall_hold_data", 64'(bus.tx_data), 64'(pd));
      end
      pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
      if (bus.done) done_cnt++;
      if (bus.error) begin
        err_cnt++;
        err_cyc = cyc;
        err_bwn = bus.block_wanted_number;
      end
      if (bus.block_wanted_number != 8'h00 && first_req_cyc < 0) first_req_cyc = cyc;
      if (bus.block_wanted_number != 8'h00 && bus.block_wanted_number != last)
        req_log.push_back(int'(bus.block_wanted_number));
      last = bus.block_wanted_number;
    end
  end

  // Block store and sink: answers a request two cycles after it appears.
  initial begin : store
    int dly, tick;
    dly = 0; tick = 0;
    bus.data_ready   = 1'b0;
    bus.block_wanted = '0;
    bus.tx_ready     = 1'b1;
    forever begin
      @(posedge clk_96MHz);
      #1;
      tick++;
      bus.tx_ready = stall ? ((tick % 3) == 0) : 1'b1;
      if (bus.block_wanted_number != 8'h00) begin
        if (store_en) begin
          if (dly < 2) dly++;
          else begin
            bus.block_wanted = blocks[int'(bus.block_wanted_number) - 1];
            bus.data_ready   = 1'b1;
          end
        end
      end else begin
        bus.data_ready = 1'b0;
        dly = 0;
      end
    end
  end

  task automatic build_exp(input int n);
    logic [47:0] w;
    logic [7:0]  b, cs;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    cs = 8'(n);
    for (int k = 0; k < n; k++) begin
      w = {7'b0, blocks[k]};
      for (int j = 0; j < 6; j++) begin
        b = w[47 - 8*j -: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef READER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic run_frame(input logic [7:0] avl, input bit restart);
    rx.delete(); req_log.delete();
    done_cnt = 0; err_cnt = 0; first_req_cyc = -1; err_cyc = -1;
    @(posedge clk_96MHz); #1;
    bus.avl_blocks_nb = avl;
    bus.start = 1'b1;
    @(posedge clk_96MHz); #1;
    bus.start = 1'b0;
    bus.avl_blocks_nb = 8'd3;
    if (restart) begin
      repeat (4) @(posedge clk_96MHz);
      #1 bus.start = 1'b1;
      @(posedge clk_96MHz);
      #1 bus.start = 1'b0;
    end
    for (int i = 0; i < 20000 && (done_cnt + err_cnt) == 0; i++) @(negedge clk_96MHz);
    if ((done_cnt + err_cnt) == 0) chk("frame_end_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk_96MHz);
  endtask

  task automatic check_frame(input string tag, input int n);
    build_exp(n);
    chk({tag, "_nbytes"}, 64'(rx.size()), 64'(exp_q.size()));
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 64'(rx[i]), 64'(exp_q[i]));
    chk({tag, "_count_byte"}, (rx.size() > 1) ? 64'(rx[1]) : 64'hDEAD, 64'(n));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_error_pulses"}, 64'(err_cnt), 64'd0);
    chk({tag, "_nreq"}, 64'(req_log.size()), 64'(n));
    for (int i = 0; i < req_log.size(); i++)
      chk({tag, "_req_order"}, 64'(req_log[i]), 64'(i + 1));
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  vec_t       vecs [0:6];
  logic [7:0] lit1 [$];

  initial begin
    bus.start = 1'b0;
    bus.avl_blocks_nb = 8'h00;
    blocks[0] = 41'h1_2345_6789AB;
    blocks[1] = 41'h0_0001_000001;
    for (int i = 2; i < 32; i++)
      blocks[i] = {1'(i % 2), 16'(i * 16'h1111), 24'(i * 24'h010203)};

    vecs[0] = '{avl: 8'd2,  stall: 1'b0, restart: 1'b0, exp_n: 2};
    vecs[1] = '{avl: 8'd0,  stall: 1'b0, restart: 1'b0, exp_n: 0};
    vecs[2] = '{avl: 8'd25, stall: 1'b0, restart: 1'b0, exp_n: 20};
    vecs[3] = '{avl: 8'd2,  stall: 1'b1, restart: 1'b0, exp_n: 2};
    vecs[4] = '{avl: 8'd20, stall: 1'b0, restart: 1'b1, exp_n: 20};
    vecs[5] = '{avl: 8'd21, stall: 1'b1, restart: 1'b0, exp_n: 20};
    vecs[6] = '{avl: 8'd1,  stall: 1'b1, restart: 1'b1, exp_n: 1};

    lit1 = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
             8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
`ifdef READER_CHECKSUM_EN
    lit1.push_back(8'h20);
`endif

    repeat (3) @(posedge clk_96MHz);
    @(negedge clk_96MHz);
    chk("rst_bwn", 64'(bus.block_wanted_number), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    @(posedge clk_96MHz); #1 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      stall = vecs[v].stall;
      run_frame(vecs[v].avl, vecs[v].restart);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_n);
      if (v == 0) begin
        chk("lit_nbytes", 64'(rx.size()), 64'(lit1.size()));
        for (int i = 0; i < rx.size() && i < lit1.size(); i++)
          chk("lit_byte", 64'(rx[i]), 64'(lit1[i]));
      end
    end
    stall = 1'b0;

    // Store never answers block 1.
    store_en = 1'b0;
    run_frame(8'd1, 1'b0);
    chk("to_error_pulses", 64'(err_cnt), 64'd1);
    chk("to_done_pulses", 64'(done_cnt), 64'd0);
    chk("to_latency", 64'(err_cyc - first_req_cyc), 64'(TIMEOUT + 1));
    chk("to_bwn_at_error", 64'(err_bwn), 64'd0);
    chk("to_nbytes", 64'(rx.size()), 64'd2);
    chk("to_busy_after", 64'(bus.busy), 64'd0);
    chk("to_bwn_after", 64'(bus.block_wanted_number), 64'd0);
    store_en = 1'b1;

    // Reset while sending block 1.
    rx.delete(); req_log.delete(); done_cnt = 0; err_cnt = 0;
    @(posedge clk_96MHz); #1;
    bus.avl_blocks_nb = 8'd2;
    bus.start = 1'b1;
    @(posedge clk_96MHz); #1 bus.start = 1'b0;
    for (int i = 0; i < 2000 && rx.size() < 3; i++) @(negedge clk_96MHz);
    chk("mr_reached_send", 64'(rx.size() >= 3), 64'd1);
    @(posedge clk_96MHz); #1 rst_n = 1'b0;
    @(posedge clk_96MHz); #1 rst_n = 1'b1;
    @(negedge clk_96MHz);
    chk("mr_bwn", 64'(bus.block_wanted_number), 64'd0);
    chk("mr_tx_data", 64'(bus.tx_data), 64'd0);
    chk("mr_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_done", 64'(bus.done), 64'd0);
    chk("mr_error", 64'(bus.error), 64'd0);
    chk("mr_no_done", 64'(done_cnt), 64'd0);
    run_frame(8'd2, 1'b0);
    check_frame("after_rst", 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
